// File: rtl/wm_plant_emulator_pkg.sv
// Shared constants and helpers for the washer plant emulator.
package wm_plant_emulator_pkg;

    localparam int FILL_CYCLES_DEF = 8;
    localparam int DET_CYCLES_DEF  = 3;
    localparam int WASH_CYCLES_DEF = 16;
    localparam int SPIN_CYCLES_DEF = 10;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int lvl_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int LVL_W_DEF = lvl_width(FILL_CYCLES_DEF);

endpackage

// File: rtl/wm_plant_emulator_if.sv
// Actuator command / sensor feedback bundle between washer controller and plant.
interface wm_plant_emulator_if
    import wm_plant_emulator_pkg::*;
#(
    parameter int FILL_CYCLES = FILL_CYCLES_DEF,
    localparam int LVL_W      = lvl_width(FILL_CYCLES)
);
    // Commands from the controller side
    logic             door_close_req;
    logic             lock;
    logic             water_valve;
    logic             soap_wash;
    logic             motor;
    logic             drain_valve;
    logic             done;
    // Feedback from the plant side
    logic             door;
    logic             filled;
    logic             drained;
    logic             detergent_add;
    logic             cycle_timeout;
    logic             spin;
    logic [LVL_W-1:0] level;
    logic             fault;

    modport master (
        output door_close_req, lock, water_valve, soap_wash, motor, drain_valve, done,
        input  door, filled, drained, detergent_add, cycle_timeout, spin, level, fault
    );

    modport slave (
        input  door_close_req, lock, water_valve, soap_wash, motor, drain_valve, done,
        output door, filled, drained, detergent_add, cycle_timeout, spin, level, fault
    );

endinterface

// File: rtl/wm_plant_emulator_timer.sv
// Saturating enable/clear cycle counter; hit flags that N cycles have elapsed.
module wm_plant_emulator_timer #(
    parameter int  N = 3,
    localparam int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         hit
);
    localparam logic [W-1:0] N_W = W'(N);

    // Count enabled cycles, stop at N; clear has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != N_W)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == N_W);

endmodule

// File: rtl/wm_plant_emulator.sv
// Washer drum/sensor plant: water level, detergent/wash/spin timers, door
// decode and sticky illegal-actuator fault flag.
module wm_plant_emulator
    import wm_plant_emulator_pkg::*;
#(
    parameter int FILL_CYCLES = FILL_CYCLES_DEF,
    parameter int DET_CYCLES  = DET_CYCLES_DEF,
    parameter int WASH_CYCLES = WASH_CYCLES_DEF,
    parameter int SPIN_CYCLES = SPIN_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    wm_plant_emulator_if.slave   bus
);
    localparam int               LVL_W   = lvl_width(FILL_CYCLES);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FILL_CYCLES);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
    localparam int               DET_W   = $clog2(DET_CYCLES + 1);
    localparam int               WASH_W  = $clog2(WASH_CYCLES + 1);
    localparam int               SPIN_W  = $clog2(SPIN_CYCLES + 1);

    logic [LVL_W-1:0] level_q;
    logic             fault_q;
    logic             det_seen_q;

    logic             filled;
    logic             drained;
    logic             fill_only;
    logic             drain_only;
    logic             illegal;

    logic             det_en, wash_en, spin_en;
    logic             det_hit, wash_hit, spin_hit;
    logic [DET_W-1:0] det_cnt;
    logic [WASH_W-1:0] wash_cnt;
    logic [SPIN_W-1:0] spin_cnt;
    logic             unused_cnt;

    assign filled     = (level_q == LVL_MAX);
    assign drained    = (level_q == '0);
    assign fill_only  = bus.water_valve & ~bus.drain_valve;
    assign drain_only = bus.drain_valve & ~bus.water_valve;

    // Any actuator combination that would damage a real machine.
    assign illegal = (bus.water_valve & bus.drain_valve)
                   | (bus.motor       & ~bus.lock)
                   | (bus.water_valve & ~bus.lock)
                   | (bus.lock        & ~bus.door_close_req);

    // Level integrates the valves and saturates at empty/full; both open holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else if (fill_only && !filled) begin
            level_q <= level_q + 1'b1;
        end else if (drain_only && !drained) begin
            level_q <= level_q - 1'b1;
        end
    end

    // Fault is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (illegal) begin
            fault_q <= 1'b1;
        end
    end

    assign det_en  = bus.soap_wash & filled;
    assign wash_en = bus.motor & bus.lock & filled;
    assign spin_en = bus.motor & bus.lock & drained;

    wm_plant_emulator_timer #(.N(DET_CYCLES)) u_det_timer (
        .clk (clk),
        .rst (rst),
        .en  (det_en),
        .clr (~det_en | bus.done),
        .cnt (det_cnt),
        .hit (det_hit)
    );

    wm_plant_emulator_timer #(.N(WASH_CYCLES)) u_wash_timer (
        .clk (clk),
        .rst (rst),
        .en  (wash_en),
        .clr (~wash_en | bus.done),
        .cnt (wash_cnt),
        .hit (wash_hit)
    );

    wm_plant_emulator_timer #(.N(SPIN_CYCLES)) u_spin_timer (
        .clk (clk),
        .rst (rst),
        .en  (spin_en),
        .clr (~spin_en | bus.done),
        .cnt (spin_cnt),
        .hit (spin_hit)
    );

    // Counts are only observed through their hit decodes.
    assign unused_cnt = ^{det_cnt, wash_cnt, spin_cnt};

    // Remember that detergent went in, so the flag outlives the dispenser
    // timer; emptying the drum (1 -> 0 step) or done forgets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_seen_q <= 1'b0;
        end else if (bus.done || (drain_only && (level_q == LVL_ONE))) begin
            det_seen_q <= 1'b0;
        end else if (det_hit) begin
            det_seen_q <= 1'b1;
        end
    end

    assign bus.door          = bus.door_close_req | bus.lock;
    assign bus.filled        = filled;
    assign bus.drained       = drained;
    assign bus.detergent_add = det_hit | det_seen_q;
    assign bus.cycle_timeout = wash_hit;
    assign bus.spin          = spin_hit;
    assign bus.level         = level_q;
    assign bus.fault         = fault_q;

endmodule
